// File: rtl/player_link_tx_if.sv
`default_nettype none
// ============================================================================
// player_link_tx_if : local player state in, remote-board GPIO/serial out
// Revision 1.0
// ============================================================================
interface player_link_tx_if;
  logic        v_tick;
  logic        dir_left;
  logic        dir_right;
  logic [11:0] xpos_player1;
  logic [1:0]  button_pressed;
  logic        gpio_left;
  logic        gpio_right;
  logic        gpio_tx;
  logic        busy;

  modport master (
    output v_tick, dir_left, dir_right, xpos_player1, button_pressed,
    input  gpio_left, gpio_right, gpio_tx, busy
  );

  modport slave (
    input  v_tick, dir_left, dir_right, xpos_player1, button_pressed,
    output gpio_left, gpio_right, gpio_tx, busy
  );
endinterface
`default_nettype wire

// File: rtl/player_link_tx.sv
`default_nettype none
// ============================================================================
// player_link_tx : per-frame GPIO direction lines plus a 19-bit UART-style
//                  snapshot frame (start, 16 data LSB-first, even parity, stop)
// Revision 1.0
// ============================================================================
module player_link_tx #(
  parameter int CLK_PER_BIT = 564
) (
  input wire              clk,
  input wire              rst,
  player_link_tx_if.slave link
);

  localparam int CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t           state_q;
  logic             v_tick_old_q;
  logic             armed_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       idx_q;
  logic [15:0]      shift_q;
  logic             parity_q;
  logic [15:0]      pend_word_q;
  logic             pend_valid_q;
  logic             gpio_left_q;
  logic             gpio_right_q;
  logic             gpio_tx_q;
  logic             busy_q;

  logic             event_d;
  logic             left_m_d;
  logic             right_m_d;
  logic             bit_end_d;
  logic [15:0]      snap_d;

  // armed_q blocks the false edge seen when v_tick is already high coming out of reset
  always_comb begin
    event_d   = link.v_tick && !v_tick_old_q && armed_q;
    left_m_d  = link.dir_left && !link.dir_right;
    right_m_d = link.dir_right && !link.dir_left;
    snap_d    = {right_m_d, left_m_d, link.button_pressed, link.xpos_player1};
    bit_end_d = (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      v_tick_old_q <= 1'b0;
      armed_q      <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      pend_word_q  <= '0;
      pend_valid_q <= 1'b0;
      gpio_left_q  <= 1'b0;
      gpio_right_q <= 1'b0;
      gpio_tx_q    <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      v_tick_old_q <= link.v_tick;
      armed_q      <= 1'b1;

      if (event_d) begin
        gpio_left_q  <= left_m_d;
        gpio_right_q <= right_m_d;
      end

      // Overridden below when the event coincides with the last stop cycle
      if (event_d && state_q != ST_IDLE) begin
        pend_word_q  <= snap_d;
        pend_valid_q <= 1'b1;
      end

      if (state_q != ST_IDLE) begin
        cnt_q <= bit_end_d ? '0 : cnt_q + CNT_ONE;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (event_d) begin
            shift_q   <= snap_d;
            parity_q  <= ^snap_d;
            cnt_q     <= '0;
            gpio_tx_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end_d) begin
            idx_q     <= '0;
            gpio_tx_q <= shift_q[0];
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end_d) begin
            if (idx_q == 4'd15) begin
              gpio_tx_q <= parity_q;
              state_q   <= ST_PARITY;
            end else begin
              shift_q   <= shift_q >> 1;
              idx_q     <= idx_q + 4'd1;
              gpio_tx_q <= shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_end_d) begin
            gpio_tx_q <= 1'b1;
            state_q   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_end_d) begin
            if (event_d) begin
              shift_q      <= snap_d;
              parity_q     <= ^snap_d;
              pend_valid_q <= 1'b0;
              gpio_tx_q    <= 1'b0;
              state_q      <= ST_START;
            end else if (pend_valid_q) begin
              shift_q      <= pend_word_q;
              parity_q     <= ^pend_word_q;
              pend_valid_q <= 1'b0;
              gpio_tx_q    <= 1'b0;
              state_q      <= ST_START;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          gpio_tx_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign link.gpio_left  = gpio_left_q;
  assign link.gpio_right = gpio_right_q;
  assign link.gpio_tx    = gpio_tx_q;
  assign link.busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_player_link_tx.sv
`default_nettype none
// ============================================================================
// tb_player_link_tx : directed vectors, multi-cycle corner cases and a
//                     randomized sweep against a frame-level reference model
// Revision 1.0
// ============================================================================
module tb_player_link_tx;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = 19 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  player_link_tx_if link();

  player_link_tx #(.CLK_PER_BIT(CPB)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (link)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dl;
    logic        dr;
    logic [1:0]  btn;
    logic [11:0] x;
    logic        el;
    logic        er;
    logic [15:0] w;
  } vec_t;

  vec_t vecs[6];

  // sweep model and receiver state
  logic [15:0] exp_q[$];
  bit          sweep_done;
  int          active_end;
  bit          pend_v;
  logic [15:0] pend_w;
  logic [18:0] rx_bits;
  logic [15:0] rx_exp;
  int          rx_frames;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input bit ok, input string what);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s", what);
    end
  endtask

  task automatic fire(input logic dl, input logic dr, input logic [1:0] btn, input logic [11:0] x);
    link.dir_left       = dl;
    link.dir_right      = dr;
    link.button_pressed = btn;
    link.xpos_player1   = x;
    link.v_tick         = 1'b1;
    tick();
    link.v_tick         = 1'b0;
  endtask

  // Called in the first start-bit cycle; returns in the cycle after the stop bit
  task automatic check_frame(input logic [15:0] w, input string tag);
    logic [18:0] f;
    int bad;
    logic act;
    f = {1'b1, ^w, w, 1'b0};
    for (int j = 0; j < 19; j++) begin
      bad = 0;
      act = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        if (link.gpio_tx !== f[j] || link.busy !== 1'b1) begin
          bad++;
          act = link.gpio_tx;
        end
        tick();
      end
      check(bad == 0, $sformatf("%s bit %0d: gpio_tx/busy wrong in %0d cycles (gpio_tx=%b busy must be 1), required gpio_tx=%b",
                                tag, j, bad, act, f[j]));
    end
  endtask

  task automatic check_idle(input int n, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (link.gpio_tx !== 1'b1 || link.busy !== 1'b0) bad++;
      tick();
    end
    check(bad == 0, $sformatf("%s: %0d of %0d cycles not idle (gpio_tx=1 busy=0 required)", tag, bad, n));
  endtask

  task automatic check_after_frame(input string tag);
    check(link.busy === 1'b0 && link.gpio_tx === 1'b1,
          $sformatf("%s end: busy=%b gpio_tx=%b, required busy=0 gpio_tx=1", tag, link.busy, link.gpio_tx));
  endtask

  // Frame-level model: one frame spans 19*CPB cycles after its load cycle
  task automatic model_step(input int t, input bit ev, input logic [15:0] w);
    if (active_end >= 0 && t == active_end) begin
      if (ev) begin
        exp_q.push_back(w); active_end = t + FRAME_CYC; pend_v = 0;
      end else if (pend_v) begin
        exp_q.push_back(pend_w); active_end = t + FRAME_CYC; pend_v = 0;
      end else begin
        active_end = -1;
      end
    end else if (ev) begin
      if (active_end < 0) begin
        exp_q.push_back(w); active_end = t + FRAME_CYC;
      end else begin
        pend_w = w; pend_v = 1;
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 2'b01, 12'h2A5, 1'b0, 1'b1, 16'h92A5};
    vecs[1] = '{1'b1, 1'b0, 2'b10, 12'h000, 1'b1, 1'b0, 16'h6000};
    vecs[2] = '{1'b1, 1'b1, 2'b11, 12'hFFF, 1'b0, 1'b0, 16'h3FFF};
    vecs[3] = '{1'b0, 1'b0, 2'b00, 12'h000, 1'b0, 1'b0, 16'h0000};
    vecs[4] = '{1'b0, 1'b1, 2'b11, 12'hFFF, 1'b0, 1'b1, 16'hBFFF};
    vecs[5] = '{1'b1, 1'b0, 2'b00, 12'h555, 1'b1, 1'b0, 16'h4555};

    // reset with v_tick held high across the release
    link.v_tick = 1'b1; link.dir_left = 1'b0; link.dir_right = 1'b1;
    link.button_pressed = 2'b00; link.xpos_player1 = 12'h0;
    rst = 1'b1;
    repeat (3) tick();
    check(link.gpio_tx === 1'b1 && link.busy === 1'b0 && link.gpio_left === 1'b0 && link.gpio_right === 1'b0,
          $sformatf("reset values: tx=%b busy=%b L=%b R=%b, required 1 0 0 0",
                    link.gpio_tx, link.busy, link.gpio_left, link.gpio_right));
    rst = 1'b0;
    tick();
    check_idle(10, "vtick high through reset");
    check(link.gpio_right === 1'b0, $sformatf("no gpio update after reset: R=%b required 0", link.gpio_right));
    link.v_tick = 1'b0;
    repeat (2) tick();

    // directed vectors
    for (int i = 0; i < 6; i++) begin
      fire(vecs[i].dl, vecs[i].dr, vecs[i].btn, vecs[i].x);
      check(link.gpio_left === vecs[i].el && link.gpio_right === vecs[i].er,
            $sformatf("vec%0d gpio: L=%b R=%b, required L=%b R=%b", i,
                      link.gpio_left, link.gpio_right, vecs[i].el, vecs[i].er));
      link.dir_left  = 1'($urandom_range(0, 1));
      link.dir_right = 1'($urandom_range(0, 1));
      check_frame(vecs[i].w, $sformatf("vec%0d", i));
      check_after_frame($sformatf("vec%0d", i));
      check(link.gpio_left === vecs[i].el && link.gpio_right === vecs[i].er,
            $sformatf("vec%0d gpio hold: L=%b R=%b, required L=%b R=%b", i,
                      link.gpio_left, link.gpio_right, vecs[i].el, vecs[i].er));
      repeat (3) tick();
    end

    // pending overwrite: events at N, N+10, N+20 -> frames xpos=1 then xpos=3
    fire(1'b0, 1'b0, 2'b00, 12'h001);
    fork
      begin
        check_frame(16'h0001, "pend first");
        check_frame(16'h0003, "pend second");
      end
      begin
        repeat (9) tick();
        link.xpos_player1 = 12'h002; link.v_tick = 1'b1; tick(); link.v_tick = 1'b0;
        repeat (9) tick();
        link.xpos_player1 = 12'h003; link.v_tick = 1'b1; tick(); link.v_tick = 1'b0;
      end
    join
    check_after_frame("pend");
    check_idle(100, "pend no third frame");

    // event coincident with the final stop cycle replaces a stale pending word
    fire(1'b0, 1'b0, 2'b00, 12'h011);
    fork
      begin
        check_frame(16'h0011, "stopedge first");
        check_frame(16'h0033, "stopedge second");
      end
      begin
        repeat (9) tick();
        link.xpos_player1 = 12'h022; link.v_tick = 1'b1; tick(); link.v_tick = 1'b0;
        repeat (65) tick();
        link.xpos_player1 = 12'h033; link.v_tick = 1'b1; tick(); link.v_tick = 1'b0;
      end
    join
    check_after_frame("stopedge");
    check_idle(100, "stopedge no stale frame");

    // v_tick held high for 50 cycles
    link.dir_left = 1'b1; link.dir_right = 1'b0; link.button_pressed = 2'b00;
    link.xpos_player1 = 12'h123; link.v_tick = 1'b1;
    fork
      begin repeat (50) tick(); link.v_tick = 1'b0; end
      begin tick(); check_frame(16'h4123, "held"); end
    join
    check_after_frame("held");
    check_idle(100, "held single frame");

    // reset in the middle of the data bits
    fire(1'b0, 1'b1, 2'b01, 12'h2A5);
    repeat (19) tick();
    rst = 1'b1;
    tick();
    check(link.gpio_tx === 1'b1 && link.busy === 1'b0 && link.gpio_left === 1'b0 && link.gpio_right === 1'b0,
          $sformatf("mid-frame reset: tx=%b busy=%b L=%b R=%b, required 1 0 0 0",
                    link.gpio_tx, link.busy, link.gpio_left, link.gpio_right));
    rst = 1'b0;
    repeat (2) tick();
    check_idle(5, "after reset idle");
    fire(1'b0, 1'b1, 2'b01, 12'h2A5);
    check_frame(16'h92A5, "post reset");
    check_after_frame("post reset");
    repeat (3) tick();

    // randomized sweep
    sweep_done = 0; active_end = -1; pend_v = 0; pend_w = '0; exp_q.delete(); rx_frames = 0;
    fork
      begin : driver
        int t;
        bit exp_busy;
        bit have_gpio;
        logic el, er;
        logic [15:0] w;
        bit ev;
        int gap;
        t = 0; exp_busy = 0; have_gpio = 0; el = 0; er = 0;
        for (int e = 0; e < 100 + 1; e++) begin
          gap = (e < 100) ? int'($urandom_range(2, 150)) : 200;
          for (int c = 0; c < gap; c++) begin
            check(link.busy === exp_busy, $sformatf("sweep busy t=%0d: %b, required %b", t, link.busy, exp_busy));
            if (have_gpio)
              check(link.gpio_left === el && link.gpio_right === er,
                    $sformatf("sweep gpio t=%0d: L=%b R=%b, required L=%b R=%b", t,
                              link.gpio_left, link.gpio_right, el, er));
            link.dir_left       = 1'($urandom_range(0, 1));
            link.dir_right      = 1'($urandom_range(0, 1));
            link.button_pressed = 2'($urandom_range(0, 3));
            link.xpos_player1   = 12'($urandom_range(0, 4095));
            ev = (e < 100) && (c == gap - 1);
            link.v_tick = ev;
            w = {link.dir_right & ~link.dir_left, link.dir_left & ~link.dir_right,
                 link.button_pressed, link.xpos_player1};
            if (ev) begin
              el = link.dir_left & ~link.dir_right;
              er = link.dir_right & ~link.dir_left;
              have_gpio = 1;
            end
            model_step(t, ev, w);
            exp_busy = (active_end >= 0);
            tick();
            t++;
          end
        end
        sweep_done = 1;
      end
      begin : receiver
        while (!sweep_done && rx_frames < 400) begin
          tick();
          if (link.gpio_tx === 1'b0) begin
            rx_frames++;
            tick(); tick();
            rx_bits[0] = link.gpio_tx;
            for (int j = 1; j < 19; j++) begin
              repeat (CPB) tick();
              rx_bits[j] = link.gpio_tx;
            end
            tick();
            check(rx_bits[0] === 1'b0, $sformatf("sweep frame %0d start bit: %b, required 0", rx_frames, rx_bits[0]));
            check(rx_bits[18] === 1'b1, $sformatf("sweep frame %0d stop bit: %b, required 1", rx_frames, rx_bits[18]));
            check((^rx_bits[17:1]) === 1'b0,
                  $sformatf("sweep frame %0d parity: data=%h parity=%b, required even", rx_frames, rx_bits[16:1], rx_bits[17]));
            if (exp_q.size() == 0) begin
              check(1'b0, $sformatf("sweep frame %0d: unexpected frame data=%h, required none", rx_frames, rx_bits[16:1]));
            end else begin
              rx_exp = exp_q.pop_front();
              check(rx_bits[16:1] === rx_exp,
                    $sformatf("sweep frame %0d data: %h, required %h", rx_frames, rx_bits[16:1], rx_exp));
            end
          end
        end
      end
    join
    check(exp_q.size() == 0, $sformatf("sweep frames not received: %0d, required 0", exp_q.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
